// File: rtl/mau_pkg.sv
// Shared types and default widths for the mem_access_unit slice.
package mau_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    VFY  = 3'd3,
    RSP  = 3'd4
  } mau_state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// Request, response and DataMem pin bundle of mem_access_unit.
// Both handshakes transfer on a rising edge where valid && ready; valid may not depend on ready.
interface mem_access_unit_if #(
  parameter int ADDR_W = mau_pkg::ADDR_W,
  parameter int DATA_W = mau_pkg::DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_datain;
  logic [DATA_W-1:0] mem_dataout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dataout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_datain
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dataout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_datain
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer for the 32x32 DataMem; one response per accepted request.
// Define MAU_WRITE_VERIFY_EN to add a read-back cycle after every store with mismatch reporting.
module mem_access_unit
  import mau_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  mem_access_unit_if.slave bus,
  output mau_state_t fsm_state
);

  mau_state_t        state_q;
  mau_state_t        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;

  assign accept = (state_q == IDLE) && bus.req_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) state_d = bus.req_we ? WR : RD;
`ifdef MAU_WRITE_VERIFY_EN
      WR:   state_d = VFY;
      VFY:  state_d = RSP;
`else
      WR:   state_d = RSP;
`endif
      RD:   state_d = RSP;
      RSP:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/data stay latched after the access so the memory pins are quiet between requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

`ifdef MAU_WRITE_VERIFY_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        RD: begin
          rdata_q <= bus.mem_dataout;
          err_q   <= 1'b0;
        end
        VFY: begin
          rdata_q <= bus.mem_dataout;
          err_q   <= (bus.mem_dataout != wdata_q);
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_err = err_q;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      case (state_q)
        WR:      rdata_q <= wdata_q;
        RD:      rdata_q <= bus.mem_dataout;
        default: ;
      endcase
    end
  end

  assign bus.rsp_err = 1'b0;
`endif

  // Memory strobe comes straight from the state register so it cannot glitch on req_*.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RSP);
  assign bus.rsp_rdata  = rdata_q;
  assign bus.mem_we     = (state_q == WR);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_datain = wdata_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + random bench for mem_access_unit with a DataMem model and a reference memory.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic       clk;
  logic       rst_n;
  mau_state_t fsm_state;
  int         n_checks;
  int         n_fail;
  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMem model: combinational read; writes of 0x12345678 land with bit 0 flipped.
  assign bus.mem_dataout = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= (bus.mem_datain == 32'h12345678) ? (bus.mem_datain ^ 32'h1) : bus.mem_datain;
    end
  end

  function automatic logic [31:0] stored_value(input logic [31:0] w);
    return (w == 32'h12345678) ? (w ^ 32'h1) : w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                     input int stall, input bit poke);
    int          lat;
    int          we_cycles;
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_lat;
    @(negedge clk);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat       = 0;
    we_cycles = 0;
    while (!bus.rsp_valid && lat < 8) begin
      check("busy_req_ready", 32'(bus.req_ready), 32'd0);
      check("busy_mem_addr", 32'(bus.mem_addr), 32'(addr));
      if (bus.mem_we) begin
        we_cycles++;
        check("store_datain", bus.mem_datain, wdata);
      end
      @(negedge clk);
      lat++;
    end
    if (we) begin
      ref_mem[addr] = stored_value(wdata);
`ifdef MAU_WRITE_VERIFY_EN
      exp_d   = ref_mem[addr];
      exp_e   = (ref_mem[addr] != wdata);
      exp_lat = 2;
`else
      exp_d   = wdata;
      exp_e   = 1'b0;
      exp_lat = 1;
`endif
    end else begin
      exp_d   = ref_mem[addr];
      exp_e   = 1'b0;
      exp_lat = 1;
    end
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("mem_we_cycles", 32'(we_cycles), we ? 32'd1 : 32'd0);
    check("rsp_rdata", bus.rsp_rdata, exp_d);
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_e));
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = ~addr;
        bus.req_wdata = $urandom;
      end
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_rsp_rdata", bus.rsp_rdata, exp_d);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      check("stall_mem_we", 32'(bus.mem_we), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic reset_during(input logic we, input logic [4:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("pre_reset_busy", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    if (we) ref_mem[addr] = stored_value(wdata);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("mid_reset_mem_we", 32'(bus.mem_we), 32'd0);
    check("mid_reset_rdata", bus.rsp_rdata, 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset_mem_we", 32'(bus.mem_we), 32'd0);
    check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset_mem_datain", bus.mem_datain, 32'd0);
    check("reset_state", 32'(fsm_state), 32'(IDLE));
    rst_n = 1'b1;

    // rsp_ready while idle must not start anything
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("idle_rsp_ready_no_effect", 32'(bus.rsp_valid), 32'd0);

    for (int a = 0; a < 32; a++) txn(1'b1, 5'(a), $urandom, 0, 1'b0);

    txn(1'b1, 5'd1, 32'hFFFFFFFF, 0, 1'b0);
    txn(1'b0, 5'd1, 32'h0, 0, 1'b0);
    txn(1'b1, 5'd0, 32'hA5A5A5A5, 1, 1'b0);
    txn(1'b1, 5'd31, 32'h5A5A5A5A, 0, 1'b0);
    txn(1'b0, 5'd0, 32'h0, 0, 1'b0);
    txn(1'b0, 5'd31, 32'h0, 2, 1'b0);
    txn(1'b0, 5'd3, 32'h0, 3, 1'b1);
    txn(1'b0, 5'd28, 32'h0, 0, 1'b0);

    reset_during(1'b0, 5'd5, 32'h0);
    reset_during(1'b1, 5'd7, 32'hCAFEF00D);
    txn(1'b0, 5'd5, 32'h0, 0, 1'b0);
    txn(1'b0, 5'd7, 32'h0, 0, 1'b0);

    txn(1'b1, 5'd9, 32'h12345678, 0, 1'b0);
    txn(1'b0, 5'd9, 32'h0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
